// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key expander and the cipher datapath.
//   byte_t     : one GF(2^8) byte
//   word_t     : four bytes, word[b] = byte b of a 32-bit column
//   key_t      : 4x4 byte matrix, key[w][b] = FIPS-197 byte 4*w+b
//   kx_state_e : key expander FSM states
//   rcon()     : AES-128 round constant lookup for rounds 1..10
package aes_pkg;

    // Rounds after round 0 for AES-128; the expander supports only this value.
    localparam int NUM_ROUNDS = 10;

    typedef logic [7:0]  byte_t;
    typedef byte_t [3:0] word_t;
    typedef word_t [3:0] key_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } kx_state_e;

    // Plain table rather than GF doubling; rounds outside 1..10 map to 0.
    function automatic byte_t rcon(input logic [3:0] round);
        byte_t val;
        case (round)
            4'd1:    val = 8'h01;
            4'd2:    val = 8'h02;
            4'd3:    val = 8'h04;
            4'd4:    val = 8'h08;
            4'd5:    val = 8'h10;
            4'd6:    val = 8'h20;
            4'd7:    val = 8'h40;
            4'd8:    val = 8'h80;
            4'd9:    val = 8'h1b;
            4'd10:   val = 8'h36;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (FIPS-197 Figure 7).
//   in_i  : input byte
//   out_o : substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t in_i,
    output byte_t out_o
);

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: accepts one cipher key, then streams round
// keys 0..10 over a valid/ready channel, one full round per accepted transfer.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holding valid keeps its payload stable until the transfer;
// ready may toggle freely and never depends combinationally on valid.
//
//   clk_i        : clock, all state on rising edge
//   rst_ni       : asynchronous active-low reset
//   key_i        : cipher key, key_i[w][b] = FIPS-197 byte 4*w+b
//   key_valid_i  : key is presented
//   key_ready_o  : expander idle and able to take a key
//   rk_o         : current round key, same layout as key_i
//   rk_idx_o     : round index of rk_o, 0..10
//   rk_last_o    : rk_o is the final round key
//   rk_valid_o   : rk_o / rk_idx_o / rk_last_o are valid
//   rk_ready_i   : consumer accepts rk_o
//   state_o      : current FSM state, for observation
module aes_key_expander
    import aes_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  key_t       key_i,
    input  logic       key_valid_i,
    output logic       key_ready_o,
    output key_t       rk_o,
    output logic [3:0] rk_idx_o,
    output logic       rk_last_o,
    output logic       rk_valid_o,
    input  logic       rk_ready_i,
    output kx_state_e  state_o
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    kx_state_e  state_q;
    key_t       rk_q;
    logic [3:0] idx_q;

    word_t      sub_word;
    word_t      temp_word;
    key_t       rk_step;

    // SubWord(RotWord(rk[3])): byte b of the rotated word is rk[3][(b+1)%4].
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (rk_q[3][(g + 1) % 4]),
            .out_o (sub_word[g])
        );
    end

    // One full round of the schedule; the round being produced is idx_q+1.
    always_comb begin
        temp_word    = sub_word;
        temp_word[0] = sub_word[0] ^ rcon(idx_q + 4'd1);
        rk_step[0]   = rk_q[0] ^ temp_word;
        rk_step[1]   = rk_q[1] ^ rk_step[0];
        rk_step[2]   = rk_q[2] ^ rk_step[1];
        rk_step[3]   = rk_q[3] ^ rk_step[2];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rk_q    <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_valid_i) begin
                        rk_q    <= key_i;
                        idx_q   <= '0;
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rk_ready_i) begin
                        if (idx_q == LAST_IDX) begin
                            // Final key stays on rk_o; only the index wraps.
                            idx_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            rk_q  <= rk_step;
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Decoded from registered state only, so rk_ready_i never reaches key_ready_o.
    assign key_ready_o = (state_q == ST_IDLE);
    assign rk_valid_o  = (state_q == ST_EMIT);
    assign rk_last_o   = (idx_q == LAST_IDX);
    assign rk_o        = rk_q;
    assign rk_idx_o    = idx_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_aes_key_expander.sv
module tb_aes_key_expander;
  import aes_pkg::*;

  logic       clk;
  logic       rst_ni;
  key_t       key;
  logic       key_valid;
  logic       key_ready;
  key_t       rk;
  logic [3:0] rk_idx;
  logic       rk_last;
  logic       rk_valid;
  logic       rk_ready;
  kx_state_e  st_dbg;

  aes_key_expander dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .key_i       (key),
    .key_valid_i (key_valid),
    .key_ready_o (key_ready),
    .rk_o        (rk),
    .rk_idx_o    (rk_idx),
    .rk_last_o   (rk_last),
    .rk_valid_o  (rk_valid),
    .rk_ready_i  (rk_ready),
    .state_o     (st_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference vectors (FIPS-197 A.1 and all-zero key) ----------------
  logic [127:0] fips_tab [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  logic [127:0] zero_tab [11] = '{
    128'h00000000000000000000000000000000,
    128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
    128'h90973450696ccffaf2f457330b0fac99,
    128'hee06da7b876a1581759e42b27e91ee2b,
    128'h7f2e2b88f8443e098dda7cbbf34b9290,
    128'hec614b851425758c99ff09376ab49ba7,
    128'h217517873550620bacaf6b3cc61bf09b,
    128'h0ef903333ba9613897060a04511dfa9f,
    128'hb1d4d8e28a7db9da1d7bb3de4c664941,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };

  function automatic key_t to_key(input logic [127:0] h);
    key_t k;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++)
        k[w][b] = h[127 - 8*(4*w + b) -: 8];
    return k;
  endfunction

  function automatic logic [127:0] to_hex(input key_t k);
    logic [127:0] h;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++)
        h[127 - 8*(4*w + b) -: 8] = k[w][b];
    return h;
  endfunction

  // ---------------- scoreboard ----------------
  logic [132:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("%0t FAIL %s: got=%0h want=%0h", $time, nm, got, want);
    end
  endtask

  task automatic push_stream(input bit zero);
    for (int i = 0; i < 11; i++)
      exp_q.push_back({zero ? zero_tab[i] : fips_tab[i], 4'(i), (i == 10)});
  endtask

  // ---------------- monitor ----------------
  int           cyc = 0;
  int           hs_cnt = 0;
  bit           stall_en = 1'b0;
  bit           gap_en = 1'b0;
  bit           last_seen = 1'b0;
  int           last_cyc = 0;
  int           gap_n = 0;
  bit           prev_stall = 1'b0;
  logic [132:0] prev_obs;

  always @(negedge clk) begin
    logic [132:0] obs;
    logic [132:0] e;
    cyc++;
    obs = {to_hex(rk), rk_idx, rk_last};
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (rk_valid) begin
        total++;
        if (key_ready) begin
          bad++;
          $display("%0t FAIL ready_in_emit: key_ready=%0b required 0", $time, key_ready);
        end
      end
      if (prev_stall) begin
        total++;
        if (obs !== prev_obs) begin
          bad++;
          $display("%0t FAIL stall_hold: now=%0h held=%0h", $time, obs, prev_obs);
        end
      end
      if (rk_valid && rk_ready) begin
        hs_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("%0t FAIL unexpected_rk: got rk=%032h idx=%0d, no entry expected",
                   $time, to_hex(rk), rk_idx);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e)
            begin
              bad++;
              $display("%0t FAIL rk_stream: got rk=%032h idx=%0d last=%0b want rk=%032h idx=%0d last=%0b",
                       $time, obs[132:5], obs[4:1], obs[0], e[132:5], e[4:1], e[0]);
            end
        end
        if (gap_en) begin
          if (rk_idx == 4'd0 && last_seen) begin
            total++;
            gap_n++;
            if (cyc - last_cyc != 2) begin
              bad++;
              $display("%0t FAIL stream_gap: got %0d cycles between last and idx0, want 2",
                       $time, cyc - last_cyc);
            end
          end
          if (rk_last) begin
            last_seen = 1'b1;
            last_cyc  = cyc;
          end
        end
      end
      prev_stall = rk_valid && !rk_ready;
      prev_obs   = obs;
    end
  end

  // ---------------- consumer ready driver ----------------
  initial rk_ready = 1'b1;
  always begin
    @(posedge clk);
    #1;
    rk_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic send_key(input logic [127:0] h);
    bit ok;
    int n;
    key       = to_key(h);
    key_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = key_ready;
      @(posedge clk);
      #1;
      n++;
    end
    key_valid = 1'b0;
    if (!ok) chk("key_accept_timeout", 128'(ok), 128'd1);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int accepts;
    int n;
    rst_ni    = 1'b0;
    key       = '0;
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rk_valid", 128'(rk_valid), 128'd0);
    chk("reset_key_ready", 128'(key_ready), 128'd1);
    chk("reset_rk", to_hex(rk), 128'd0);
    chk("reset_rk_idx", 128'(rk_idx), 128'd0);
    chk("reset_state", 128'(st_dbg), 128'(ST_IDLE));
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // 1: FIPS-197 A.1 key, consumer always ready
    push_stream(1'b0);
    send_key(fips_tab[0]);
    chk("t1_latency_valid", 128'(rk_valid), 128'd1);
    chk("t1_latency_idx", 128'(rk_idx), 128'd0);
    drain(100);
    @(posedge clk);
    #1;
    chk("t1_key_ready_after_last", 128'(key_ready), 128'd1);
    chk("t1_rk_holds_last", to_hex(rk), fips_tab[10]);

    // 2: all-zero key
    push_stream(1'b1);
    send_key(128'd0);
    drain(100);

    // 3: random consumer stalls
    @(posedge clk);
    #1;
    hs_cnt   = 0;
    stall_en = 1'b1;
    push_stream(1'b0);
    send_key(fips_tab[0]);
    drain(500);
    stall_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_handshakes", 128'(hs_cnt), 128'd11);

    // 4: key_valid held with a changing key during EMIT
    @(posedge clk);
    #1;
    push_stream(1'b0);
    push_stream(1'b1);
    key       = to_key(fips_tab[0]);
    key_valid = 1'b1;
    accepts   = 0;
    n         = 0;
    while (accepts < 2 && n < 100) begin
      @(negedge clk);
      if (key_ready && key_valid) accepts++;
      @(posedge clk);
      #1;
      n++;
      if (accepts >= 2) key_valid = 1'b0;
      else if (accepts == 1)
        key = (rk_valid && !rk_last) ? to_key({$urandom, $urandom, $urandom, $urandom})
                                     : to_key(128'd0);
    end
    key_valid = 1'b0;
    chk("t4_accepts", 128'(accepts), 128'd2);
    drain(100);

    // 5: asynchronous reset in the middle of round 5
    @(posedge clk);
    #1;
    push_stream(1'b0);
    send_key(fips_tab[0]);
    n = 0;
    while (rk_idx != 4'd5 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("t5_reached_idx5", 128'(rk_idx), 128'd5);
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_rk_valid", 128'(rk_valid), 128'd0);
    chk("t5_rst_rk", to_hex(rk), 128'd0);
    chk("t5_rst_key_ready", 128'(key_ready), 128'd1);
    chk("t5_rst_idx", 128'(rk_idx), 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    push_stream(1'b1);
    send_key(128'd0);
    drain(100);

    // 6: back-to-back keys, one idle cycle between streams
    @(posedge clk);
    #1;
    gap_en    = 1'b1;
    last_seen = 1'b0;
    gap_n     = 0;
    push_stream(1'b0);
    push_stream(1'b0);
    key       = to_key(fips_tab[0]);
    key_valid = 1'b1;
    accepts   = 0;
    n         = 0;
    while (accepts < 2 && n < 100) begin
      @(negedge clk);
      if (key_ready) accepts++;
      @(posedge clk);
      #1;
      n++;
    end
    key_valid = 1'b0;
    drain(100);
    gap_en = 1'b0;
    chk("t6_gap_observed", 128'(gap_n), 128'd1);
    repeat (3) @(negedge clk);
    chk("t6_idle_after", 128'(rk_valid), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
